// File: rtl/pwm_update_event_gen_if.sv
// rtl/pwm_update_event_gen_if.sv - carrier, commit and strobe signals of the PWM update event generator
interface pwm_update_event_gen_if #(
    parameter int PRESC_W = 8
);
    logic               carrier_zero;
    logic               carrier_peak;
    logic [1:0]         mode;
    logic [PRESC_W-1:0] presc;
    logic               commit;
    logic               overrun_clr;
    logic               mask_event;
    logic               pending;
    logic               overrun;

    modport master (
        output carrier_zero, carrier_peak, mode, presc, commit, overrun_clr,
        input  mask_event, pending, overrun
    );

    modport slave (
        input  carrier_zero, carrier_peak, mode, presc, commit, overrun_clr,
        output mask_event, pending, overrun
    );
endinterface

// File: rtl/pwm_update_event_gen.sv
// rtl/pwm_update_event_gen.sv - carrier-synchronous shadow-register update strobe generator
// Optional UPDATE_AUTO_EN adds auto_upd for continuous reload on every prescaled tick.
module pwm_update_event_gen #(
    parameter int PRESC_W = 8
) (
    input  logic clk,
    input  logic reset,
`ifdef UPDATE_AUTO_EN
    input  logic auto_upd,
`endif
    pwm_update_event_gen_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        FIRE  = 2'b10
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PRESC_W-1:0] pcnt;
    logic               qual;
    logic               tick;
    logic               immediate;
    logic               auto_on;
    logic               overrun_q;

`ifdef UPDATE_AUTO_EN
    assign auto_on = auto_upd;
`else
    assign auto_on = 1'b0;
`endif

    assign immediate = (bus.mode == 2'b11);

    // Simultaneous zero and peak in mode 10 collapse into a single qualifying event.
    always_comb begin
        qual = 1'b0;
        case (bus.mode)
            2'b00:   qual = bus.carrier_zero;
            2'b01:   qual = bus.carrier_peak;
            2'b10:   qual = bus.carrier_zero | bus.carrier_peak;
            default: qual = 1'b0;
        endcase
    end

    assign tick = qual && (pcnt == '0);

    // Free-running decimator; presc is only sampled on reload so a change never shortens a running count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt <= '0;
        end else if (qual) begin
            if (pcnt == '0) begin
                pcnt <= bus.presc;
            end else begin
                pcnt <= pcnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A commit coinciding with a tick arms rather than fires, giving staged writes a full boundary to settle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.commit && immediate) begin
                    state_nxt = FIRE;
                end else if (auto_on && (tick || immediate)) begin
                    state_nxt = FIRE;
                end else if (bus.commit) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (tick || immediate) begin
                    state_nxt = FIRE;
                end
            end
            FIRE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The encoding makes each output a single state flop, so both are glitch-free registered outputs.
    always_comb begin
        bus.mask_event = (state == FIRE);
        bus.pending    = (state == ARMED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (bus.commit && (state != IDLE)) begin
            overrun_q <= 1'b1;
        end else if (bus.overrun_clr) begin
            overrun_q <= 1'b0;
        end
    end

    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_pwm_update_event_gen.sv
// tb/tb_pwm_update_event_gen.sv - self-checking bench for pwm_update_event_gen
module tb_pwm_update_event_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
`ifdef UPDATE_AUTO_EN
    logic auto_upd = 1'b0;
`endif

    pwm_update_event_gen_if #(.PRESC_W(8)) bus ();

    pwm_update_event_gen #(.PRESC_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
`ifdef UPDATE_AUTO_EN
        .auto_upd (auto_upd),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(string name, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b at t=%0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: ticks are the qual events whose index hits a schedule spaced presc+1 apart.
    int unsigned qidx = 0;
    int unsigned next_tick = 0;
    bit m_armed = 0;
    bit exp_mask = 0;
    bit exp_pend = 0;
    bit exp_ovr = 0;

    task automatic model_step();
        bit qual, tk, m3, busy, auto_v, fire, arm;
        m3 = (bus.mode == 2'd3);
        case (bus.mode)
            2'd0:    qual = bus.carrier_zero;
            2'd1:    qual = bus.carrier_peak;
            2'd2:    qual = bus.carrier_zero || bus.carrier_peak;
            default: qual = 0;
        endcase
        tk = 0;
        if (qual) begin
            if (qidx == next_tick) begin
                tk = 1;
                next_tick = qidx + 32'(bus.presc) + 1;
            end
            qidx++;
        end
`ifdef UPDATE_AUTO_EN
        auto_v = auto_upd;
`else
        auto_v = 0;
`endif
        busy = m_armed || exp_mask;
        if (bus.commit && busy) exp_ovr = 1;
        else if (bus.overrun_clr) exp_ovr = 0;
        fire = (m_armed && (tk || m3)) ||
               (!busy && ((bus.commit && m3) || (auto_v && (tk || m3))));
        arm  = (m_armed && !(tk || m3)) ||
               (!busy && bus.commit && !m3 && !(auto_v && tk));
        m_armed  = arm;
        exp_mask = fire;
        exp_pend = arm;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                qidx = 0; next_tick = 0; m_armed = 0;
                exp_mask = 0; exp_pend = 0; exp_ovr = 0;
            end else begin
                model_step();
            end
        end
    end

    int cyc = 0;
    int last_mask = -100;

    initial begin
        forever begin
            @(negedge clk);
            check("model_mask_event", bus.mask_event, exp_mask);
            check("model_pending", bus.pending, exp_pend);
            check("model_overrun", bus.overrun, exp_ovr);
            if (bus.mask_event) begin
                n_checks++;
                if (cyc - last_mask < 2) begin
                    n_fail++;
                    $display("FAIL strobe_spacing: got %0d cycles, expected >= 2", cyc - last_mask);
                end
                last_mask = cyc;
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.carrier_zero = 0; bus.carrier_peak = 0; bus.commit = 0; bus.overrun_clr = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    bit fired [1:8];

    initial begin
        bus.carrier_zero = 0; bus.carrier_peak = 0; bus.commit = 0; bus.overrun_clr = 0;
        bus.mode = 2'd0; bus.presc = 8'd0;

        // Reset state
        do_reset();
        @(negedge clk);
        check("reset_mask_event", bus.mask_event, 1'b0);
        check("reset_pending", bus.pending, 1'b0);
        check("reset_overrun", bus.overrun, 1'b0);

        // Mode 00, presc 0: pending through the wait, single strobe after the zero pulse
        step();
        bus.commit = 1; step(); bus.commit = 0;
        @(negedge clk);
        check("m00_pending_rise", bus.pending, 1'b1);
        check("m00_no_early_strobe", bus.mask_event, 1'b0);
        repeat (39) step();
        check("m00_pending_hold", bus.pending, 1'b1);
        bus.carrier_zero = 1; step(); bus.carrier_zero = 0;
        @(negedge clk);
        check("m00_strobe", bus.mask_event, 1'b1);
        check("m00_pending_fall", bus.pending, 1'b0);
        step();
        @(negedge clk);
        check("m00_strobe_one_cycle", bus.mask_event, 1'b0);

        // Mode 01, presc 2: fire on peak 1, recommit, fire on peak 4 only
        do_reset();
        bus.mode = 2'd1; bus.presc = 8'd2;
        step();
        bus.commit = 1; step(); bus.commit = 0; step();
        for (int p = 1; p <= 6; p++) begin
            if (p == 2) begin
                bus.commit = 1; step(); bus.commit = 0; step();
            end
            bus.carrier_peak = 1; step(); bus.carrier_peak = 0;
            @(negedge clk);
            fired[p] = bus.mask_event;
            step(); step();
        end
        for (int p = 1; p <= 6; p++)
            check($sformatf("m01_presc2_peak%0d", p), fired[p], (p == 1 || p == 4));

        // Mode 11: strobe the cycle after commit, never pending
        do_reset();
        bus.mode = 2'd3;
        step();
        bus.commit = 1; step(); bus.commit = 0;
        @(negedge clk);
        check("m11_strobe", bus.mask_event, 1'b1);
        check("m11_no_pending", bus.pending, 1'b0);
        step();
        @(negedge clk);
        check("m11_strobe_end", bus.mask_event, 1'b0);

        // Commit coincident with tick, then overrun handling
        do_reset();
        bus.mode = 2'd0; bus.presc = 8'd0;
        step();
        bus.commit = 1; bus.carrier_zero = 1; step(); bus.commit = 0; bus.carrier_zero = 0;
        @(negedge clk);
        check("same_tick_no_strobe", bus.mask_event, 1'b0);
        check("same_tick_armed", bus.pending, 1'b1);
        step();
        bus.commit = 1; step(); bus.commit = 0;
        @(negedge clk);
        check("overrun_set", bus.overrun, 1'b1);
        step();
        bus.carrier_zero = 1; step(); bus.carrier_zero = 0;
        @(negedge clk);
        check("overrun_strobe", bus.mask_event, 1'b1);
        step();
        @(negedge clk);
        check("overrun_single_strobe", bus.mask_event, 1'b0);
        check("overrun_sticky", bus.overrun, 1'b1);
        step();
        bus.overrun_clr = 1; step(); bus.overrun_clr = 0;
        @(negedge clk);
        check("overrun_clr", bus.overrun, 1'b0);
        step();
        bus.commit = 1; step(); bus.commit = 0; step();
        bus.commit = 1; bus.overrun_clr = 1; step(); bus.commit = 0; bus.overrun_clr = 0;
        @(negedge clk);
        check("overrun_set_beats_clr", bus.overrun, 1'b1);

        // Asynchronous reset while armed discards the update
        do_reset();
        bus.mode = 2'd0; bus.presc = 8'd0;
        step();
        bus.commit = 1; step(); bus.commit = 0;
        @(negedge clk);
        check("areset_armed", bus.pending, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("areset_pending_now", bus.pending, 1'b0);
        check("areset_mask_now", bus.mask_event, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int b = 0; b < 3; b++) begin
            step();
            bus.carrier_zero = 1; step(); bus.carrier_zero = 0;
            @(negedge clk);
            check($sformatf("areset_no_strobe%0d", b), bus.mask_event, 1'b0);
        end

`ifdef UPDATE_AUTO_EN
        // Auto update: mode 10, presc 1, alternating boundaries fire every second one
        do_reset();
        bus.mode = 2'd2; bus.presc = 8'd1; auto_upd = 1'b1;
        step();
        for (int b = 1; b <= 8; b++) begin
            if (b % 2 == 1) bus.carrier_zero = 1;
            else            bus.carrier_peak = 1;
            step();
            bus.carrier_zero = 0; bus.carrier_peak = 0;
            @(negedge clk);
            fired[b] = bus.mask_event;
            step();
        end
        for (int b = 1; b <= 8; b++)
            check($sformatf("auto_boundary%0d", b), fired[b], (b % 2 == 1));
        auto_upd = 1'b0;
`endif

        // Randomized traffic against the model
        do_reset();
        bus.mode = 2'd0; bus.presc = 8'd0;
        for (int i = 0; i < 4000; i++) begin
            step();
            bus.carrier_zero = ($urandom_range(0, 5) == 0);
            bus.carrier_peak = ($urandom_range(0, 5) == 0);
            bus.commit       = ($urandom_range(0, 11) == 0);
            bus.overrun_clr  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 59) == 0) bus.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) bus.presc = 8'($urandom_range(0, 3));
`ifdef UPDATE_AUTO_EN
            if ($urandom_range(0, 199) == 0) auto_upd = ~auto_upd;
`endif
        end
        step();
        bus.carrier_zero = 0; bus.carrier_peak = 0; bus.commit = 0; bus.overrun_clr = 0;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pwm_update_event_gen.md
# pwm_update_event_gen

Generates the one-cycle `mask_event` strobe that the PWM shadow-register mask blocks use to transfer staged duty, period and deadtime values into their active registers. It sits between the software/AXI register interface and the PWM carrier counter. It accepts a commit request from software and arms an update. It then fires the strobe only at a carrier-synchronous boundary: counter zero, peak, or both, optionally decimated by a prescaler. This keeps a PWM period from ever running with a half-updated register set.

## Interface
- `PRESC_W`, default 8: width of the update prescaler (update every `presc+1` qualifying carrier events).
- `clk` input, 1 bit: system clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-high. Clock is `clk`.
- `carrier_zero` input, 1 bit: single-cycle pulse when the carrier counter equals 0.
- `carrier_peak` input, 1 bit: single-cycle pulse when the carrier counter equals its period value.
- `mode` input, 2 bits: 00 = update at zero, 01 = at peak, 10 = at zero or peak, 11 = immediate.
- `presc` input, `PRESC_W` bits: decimation of qualifying events.
- `commit` input, 1 bit: single-cycle request from software indicating staged registers are complete.
- `mask_event` output, 1 bit: single-cycle update strobe to all shadow-register masks.
- `pending` output, 1 bit: high while a commit is armed and waiting for its boundary.
- `overrun` output, 1 bit: sticky; set when `commit` arrives while already pending.
- `overrun_clr` input, 1 bit: synchronous clear of `overrun`.

## Operation
- Qualifying event (`qual`):
  - mode 00: `carrier_zero`.
  - mode 01: `carrier_peak`.
  - mode 10: `carrier_zero | carrier_peak`.
  - mode 11: none; `qual` is never asserted.
- Prescaler counter `pcnt` (`PRESC_W` bits) runs free on `qual`.
  - On `qual` with `pcnt == 0`: assert internal `tick`, reload `pcnt <= presc`.
  - On `qual` with `pcnt != 0`: decrement.
  - A new `presc` value takes effect only at the next reload.
- FSM states:
  - IDLE: on `commit`, go to ARMED (modes 00–10) or FIRE (mode 11).
  - ARMED: `pending` = 1. On `tick`, go to FIRE. If `mode` changes to 11 while ARMED, go to FIRE on the next cycle.
  - FIRE: `mask_event` = 1 for exactly one cycle, then go to IDLE.
- Commit in the same cycle as `tick` while IDLE: not serviced by that tick. The FSM goes to ARMED and waits for the next tick. Software writes may still be settling in that cycle.
- Commit while ARMED or FIRE:
  - No second strobe is queued.
  - Set `overrun`.
  - The armed update still fires once and carries the latest staged values.
- `overrun_clr` and `commit` with pending in the same cycle: the set wins.
- `carrier_zero` and `carrier_peak` in the same cycle in mode 10 count as one `qual`.
- Reset mid-operation: the FSM goes to IDLE and any armed update is discarded. Software must re-commit.

## Timing
- Reset values:
  - `mask_event` = 0, `pending` = 0, `overrun` = 0.
  - `pcnt` = 0, so the first `qual` after reset is a tick.
- All outputs are registered.
- Latency, modes 00–10: `mask_event` is high in the cycle after the `tick` cycle, one cycle after the boundary pulse.
- Latency, mode 11: `mask_event` is high in the cycle after `commit`.
- `pending` rises the cycle after `commit` and falls in the same cycle `mask_event` rises.
- Minimum spacing between two `mask_event` pulses is 2 cycles.

## Configuration
- `UPDATE_AUTO_EN`
  - Defined: adds input `auto_upd` (1 bit). While `auto_upd` = 1, every `tick` produces `mask_event` without needing `commit`, for continuous shadow reload. In mode 11 with `auto_upd` = 1, `mask_event` is asserted every other cycle.
  - Undefined: the port is absent and updates occur only after `commit`.

## Test plan
- Mode 00, presc = 0: `commit` at cycle 10, `carrier_zero` at cycle 50 -> `pending` high in cycles 11–50, `mask_event` high only in cycle 51.
- Mode 01, presc = 2: `commit`, then `carrier_peak` pulses ×6 -> `mask_event` after the 1st tick only. Recommit: fires after the 4th peak (counter sequence 0,2,1,0).
- Mode 11: `commit` at cycle 5 -> `mask_event` at cycle 6, `pending` never high.
- `commit` in the same cycle as a `carrier_zero` tick (mode 00, presc = 0) -> no strobe then, strobe after the next `carrier_zero`. A second `commit` while pending -> `overrun` = 1, only one `mask_event`, and `overrun_clr` returns it to 0.
- Assert `reset` asynchronously while ARMED -> `pending` and `mask_event` go to 0 immediately, and no strobe follows later boundaries without a new `commit`.
- With `UPDATE_AUTO_EN` defined, mode 10, presc = 1, `auto_upd` = 1, alternating zero/peak pulses -> `mask_event` on every 2nd boundary with no `commit`.
